// File: rtl/jedro_1_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : jedro_1_mem_arbiter
// Purpose  : Shares one single-port, byte-write RAM with 1-cycle read latency
//            between the jedro_1 instruction-fetch port (read-only) and the
//            data port (read/write). One grant per cycle. Data has priority,
//            but fetch is granted after MAX_DATA_STREAK consecutive data
//            grants that it waited through.
// Ports    : clk_i / rstn_i           clock, async active-low reset
//            instr_req/addr -> gnt    fetch request side (combinational gnt)
//            instr_rvalid/rdata       fetch response, 1 cycle after grant
//            data_req/we/addr/wdata   data request side (combinational gnt)
//            data_rvalid/rdata        data response (reads and write acks)
//            mem_en/we/addr/wdata     RAM request, driven by the granted port
//            mem_rdata_i              RAM read data, valid cycle after mem_en
// Revision : 1.0 - initial release
// ============================================================================
module jedro_1_mem_arbiter #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  input  logic                    instr_req_i,
  input  logic [ADDR_WIDTH-1:0]   instr_addr_i,
  output logic                    instr_gnt_o,
  output logic                    instr_rvalid_o,
  output logic [DATA_WIDTH-1:0]   instr_rdata_o,
  input  logic                    data_req_i,
  input  logic [DATA_WIDTH/8-1:0] data_we_i,
  input  logic [ADDR_WIDTH-1:0]   data_addr_i,
  input  logic [DATA_WIDTH-1:0]   data_wdata_i,
  output logic                    data_gnt_o,
  output logic                    data_rvalid_o,
  output logic [DATA_WIDTH-1:0]   data_rdata_o,
  output logic                    mem_en_o,
  output logic [DATA_WIDTH/8-1:0] mem_we_o,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i
);

  localparam int       WE_WIDTH   = DATA_WIDTH / 8;
  localparam logic [3:0] STREAK_MAX = 4'(MAX_DATA_STREAK);

  // Response owner encoding
  localparam logic [1:0] RESP_NONE  = 2'd0;
  localparam logic [1:0] RESP_INSTR = 2'd1;
  localparam logic [1:0] RESP_DATA  = 2'd2;

  logic [1:0] resp_q, resp_d;
  logic [3:0] streak_q, streak_d;
  logic       grant_instr, grant_data;

  // Grant decision. Fetch only beats a competing data request once the data
  // streak has reached its limit. Everything is gated off while in reset.
  always_comb begin
    grant_instr = 1'b0;
    grant_data  = 1'b0;
    if (rstn_i) begin
      if (data_req_i && !(instr_req_i && (streak_q == STREAK_MAX))) begin
        grant_data = 1'b1;
      end else if (instr_req_i) begin
        grant_instr = 1'b1;
      end
    end
  end

  assign instr_gnt_o = grant_instr;
  assign data_gnt_o  = grant_data;

  // RAM request mux; fetch never writes, idle drives everything low.
  always_comb begin
    mem_en_o    = 1'b0;
    mem_we_o    = '0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (grant_data) begin
      mem_en_o    = 1'b1;
      mem_we_o    = data_we_i;
      mem_addr_o  = data_addr_i;
      mem_wdata_o = data_wdata_i;
    end else if (grant_instr) begin
      mem_en_o    = 1'b1;
      mem_we_o    = {WE_WIDTH{1'b0}};
      mem_addr_o  = instr_addr_i;
    end
  end

  // State register: response owner and data-streak counter
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      resp_q   <= RESP_NONE;
      streak_q <= 4'd0;
    end else begin
      resp_q   <= resp_d;
      streak_q <= streak_d;
    end
  end

  // Next-state logic
  always_comb begin
    resp_d = RESP_NONE;
    if (grant_data) begin
      resp_d = RESP_DATA;
    end else if (grant_instr) begin
      resp_d = RESP_INSTR;
    end

    // Streak only counts data grants that fetch actually waited through.
    streak_d = streak_q;
    if (grant_instr || !instr_req_i) begin
      streak_d = 4'd0;
    end else if (grant_data && (streak_q != STREAK_MAX)) begin
      streak_d = streak_q + 4'd1;
    end
  end

  // Response routing: only the owner sees valid and read data.
  always_comb begin
    instr_rvalid_o = 1'b0;
    instr_rdata_o  = '0;
    data_rvalid_o  = 1'b0;
    data_rdata_o   = '0;
    case (resp_q)
      RESP_INSTR: begin
        instr_rvalid_o = 1'b1;
        instr_rdata_o  = mem_rdata_i;
      end
      RESP_DATA: begin
        data_rvalid_o = 1'b1;
        data_rdata_o  = mem_rdata_i;
      end
      default: begin
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_jedro_1_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_jedro_1_mem_arbiter
// Purpose  : Self-checking bench for jedro_1_mem_arbiter with a small
//            byte-write RAM model on the mem_* side. Inputs change 1 time
//            unit after the rising edge; outputs are sampled on the falling
//            edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_jedro_1_mem_arbiter;

  logic        clk = 1'b0;
  logic        rstn;
  logic        instr_req;
  logic [31:0] instr_addr;
  logic        instr_gnt;
  logic        instr_rvalid;
  logic [31:0] instr_rdata;
  logic        data_req;
  logic [3:0]  data_we;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_gnt;
  logic        data_rvalid;
  logic [31:0] data_rdata;
  logic        mem_en;
  logic [3:0]  mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  jedro_1_mem_arbiter #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .MAX_DATA_STREAK(4)
  ) dut (
    .clk_i         (clk),
    .rstn_i        (rstn),
    .instr_req_i   (instr_req),
    .instr_addr_i  (instr_addr),
    .instr_gnt_o   (instr_gnt),
    .instr_rvalid_o(instr_rvalid),
    .instr_rdata_o (instr_rdata),
    .data_req_i    (data_req),
    .data_we_i     (data_we),
    .data_addr_i   (data_addr),
    .data_wdata_i  (data_wdata),
    .data_gnt_o    (data_gnt),
    .data_rvalid_o (data_rvalid),
    .data_rdata_o  (data_rdata),
    .mem_en_o      (mem_en),
    .mem_we_o      (mem_we),
    .mem_addr_o    (mem_addr),
    .mem_wdata_o   (mem_wdata),
    .mem_rdata_i   (mem_rdata)
  );

  // RAM model: 256 words, read-before-write, 1-cycle read latency.
  // Word at byte address A initially holds 0xC0DE0000 + A, except 0x104.
  logic [31:0] ram [0:255];
  logic [31:0] ram_word;
  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 32'hC0DE_0000 + 32'(i * 4);
    ram[65] = 32'h1122_3344;
    mem_rdata = 32'h0;
  end
  always @(posedge clk) begin
    if (mem_en) begin
      ram_word  = ram[mem_addr[9:2]];
      mem_rdata <= ram_word;
      for (int b = 0; b < 4; b++) begin
        if (mem_we[b]) ram_word[b*8 +: 8] = mem_wdata[b*8 +: 8];
      end
      ram[mem_addr[9:2]] <= ram_word;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic ir, input logic [31:0] ia, input logic dr,
                       input logic [3:0] we, input logic [31:0] da, input logic [31:0] wd);
    instr_req  = ir;
    instr_addr = ia;
    data_req   = dr;
    data_we    = we;
    data_addr  = da;
    data_wdata = wd;
  endtask

  typedef struct {
    logic        ir;
    logic [31:0] ia;
    logic        dr;
    logic [3:0]  we;
    logic [31:0] da;
    logic [31:0] wd;
    logic        e_igt;
    logic        e_dgt;
    logic        e_en;
    logic [3:0]  e_we;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic        e_irv;
    logic [31:0] e_ird;
    logic        e_drv;
    logic [31:0] e_drd;
    logic        chk_drd;
  } vec_t;

  vec_t vecs [9];

  initial begin
    // ir ia dr we da wd | igt dgt en we addr wdata | irv ird drv drd chk_drd
    // Fetch stream with a non-requesting data port parked on write values
    vecs[0] = '{1, 32'h0, 0, 4'hF, 32'h300, 32'h12345678, 1, 0, 1, 4'h0, 32'h0, 32'h0,
                0, 32'h0, 0, 32'h0, 1};
    vecs[1] = '{1, 32'h4, 0, 4'hF, 32'h300, 32'h12345678, 1, 0, 1, 4'h0, 32'h4, 32'h0,
                1, 32'hC0DE0000, 0, 32'h0, 1};
    vecs[2] = '{1, 32'h8, 0, 4'hF, 32'h300, 32'h12345678, 1, 0, 1, 4'h0, 32'h8, 32'h0,
                1, 32'hC0DE0004, 0, 32'h0, 1};
    // Full-word write then read of 0x100
    vecs[3] = '{0, 32'h0, 1, 4'hF, 32'h100, 32'hDEADBEEF, 0, 1, 1, 4'hF, 32'h100, 32'hDEADBEEF,
                1, 32'hC0DE0008, 0, 32'h0, 1};
    vecs[4] = '{0, 32'h0, 1, 4'h0, 32'h100, 32'h0, 0, 1, 1, 4'h0, 32'h100, 32'h0,
                0, 32'h0, 1, 32'h0, 0};
    // Byte-lane write into 0x104 (holds 0x11223344), then read back
    vecs[5] = '{0, 32'h0, 1, 4'h2, 32'h104, 32'h0000AB00, 0, 1, 1, 4'h2, 32'h104, 32'h0000AB00,
                0, 32'h0, 1, 32'hDEADBEEF, 1};
    vecs[6] = '{0, 32'h0, 1, 4'h0, 32'h104, 32'h0, 0, 1, 1, 4'h0, 32'h104, 32'h0,
                0, 32'h0, 1, 32'h0, 0};
    // Idle with junk on the data inputs: mem_* must stay zero
    vecs[7] = '{0, 32'h40, 0, 4'hF, 32'h200, 32'h55, 0, 0, 0, 4'h0, 32'h0, 32'h0,
                0, 32'h0, 1, 32'h1122AB44, 1};
    vecs[8] = '{0, 32'h40, 0, 4'hF, 32'h200, 32'h55, 0, 0, 0, 4'h0, 32'h0, 32'h0,
                0, 32'h0, 0, 32'h0, 1};

    // ---------------- reset state (requests active, all gated) -------------
    rstn = 1'b0;
    drive(1, 32'h10, 1, 4'h0, 32'h20, 32'h0);
    @(negedge clk);
    chk("rst instr_gnt", 32'(instr_gnt), 32'h0);
    chk("rst data_gnt", 32'(data_gnt), 32'h0);
    chk("rst mem_en", 32'(mem_en), 32'h0);
    chk("rst mem_addr", mem_addr, 32'h0);
    chk("rst instr_rvalid", 32'(instr_rvalid), 32'h0);
    chk("rst data_rvalid", 32'(data_rvalid), 32'h0);
    chk("rst data_rdata", data_rdata, 32'h0);
    @(posedge clk); #1;
    rstn = 1'b1;
    drive(0, 32'h0, 0, 4'h0, 32'h0, 32'h0);

    // ---------------- table-driven vectors --------------------------------
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1;
      drive(vecs[i].ir, vecs[i].ia, vecs[i].dr, vecs[i].we, vecs[i].da, vecs[i].wd);
      @(negedge clk);
      chk($sformatf("v%0d instr_gnt", i), 32'(instr_gnt), 32'(vecs[i].e_igt));
      chk($sformatf("v%0d data_gnt", i), 32'(data_gnt), 32'(vecs[i].e_dgt));
      chk($sformatf("v%0d mem_en", i), 32'(mem_en), 32'(vecs[i].e_en));
      chk($sformatf("v%0d mem_we", i), 32'(mem_we), 32'(vecs[i].e_we));
      chk($sformatf("v%0d mem_addr", i), mem_addr, vecs[i].e_addr);
      chk($sformatf("v%0d mem_wdata", i), mem_wdata, vecs[i].e_wdata);
      chk($sformatf("v%0d instr_rvalid", i), 32'(instr_rvalid), 32'(vecs[i].e_irv));
      chk($sformatf("v%0d instr_rdata", i), instr_rdata, vecs[i].e_ird);
      chk($sformatf("v%0d data_rvalid", i), 32'(data_rvalid), 32'(vecs[i].e_drv));
      if (vecs[i].chk_drd)
        chk($sformatf("v%0d data_rdata", i), data_rdata, vecs[i].e_drd);
    end

    // ---------------- contention: D,D,D,D,I repeating ---------------------
    for (int k = 0; k < 11; k++) begin
      @(posedge clk); #1;
      if (k < 10) drive(1, 32'h10, 1, 4'h0, 32'h20, 32'h0);
      else        drive(0, 32'h0, 0, 4'h0, 32'h0, 32'h0);
      @(negedge clk);
      if (k < 10) begin
        chk($sformatf("rr%0d streak", k), 32'(dut.streak_q), 32'(k % 5));
        chk($sformatf("rr%0d data_gnt", k), 32'(data_gnt), (k % 5 == 4) ? 32'h0 : 32'h1);
        chk($sformatf("rr%0d instr_gnt", k), 32'(instr_gnt), (k % 5 == 4) ? 32'h1 : 32'h0);
      end
      if (k > 0) begin
        // response of the grant made in cycle k-1
        if ((k - 1) % 5 == 4) begin
          chk($sformatf("rr%0d instr_rvalid", k), 32'(instr_rvalid), 32'h1);
          chk($sformatf("rr%0d instr_rdata", k), instr_rdata, 32'hC0DE0010);
          chk($sformatf("rr%0d data_rvalid", k), 32'(data_rvalid), 32'h0);
        end else begin
          chk($sformatf("rr%0d data_rvalid", k), 32'(data_rvalid), 32'h1);
          chk($sformatf("rr%0d data_rdata", k), data_rdata, 32'hC0DE0020);
          chk($sformatf("rr%0d instr_rvalid", k), 32'(instr_rvalid), 32'h0);
        end
      end
    end

    // ---------------- reset right after a data read grant ----------------
    @(posedge clk); #1;
    drive(1, 32'h10, 1, 4'h0, 32'h8, 32'h0);
    @(negedge clk);
    chk("rstseq data_gnt", 32'(data_gnt), 32'h1);
    @(posedge clk); #1;
    rstn = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk($sformatf("rstseq%0d data_rvalid", k), 32'(data_rvalid), 32'h0);
      chk($sformatf("rstseq%0d data_gnt", k), 32'(data_gnt), 32'h0);
      chk($sformatf("rstseq%0d mem_en", k), 32'(mem_en), 32'h0);
      chk($sformatf("rstseq%0d streak", k), 32'(dut.streak_q), 32'h0);
      @(posedge clk); #1;
    end
    rstn = 1'b1;
    drive(1, 32'h10, 0, 4'h0, 32'h0, 32'h0);
    @(negedge clk);
    chk("rstrel instr_gnt", 32'(instr_gnt), 32'h1);
    chk("rstrel streak", 32'(dut.streak_q), 32'h0);
    chk("rstrel data_rvalid", 32'(data_rvalid), 32'h0);
    @(posedge clk); #1;
    drive(0, 32'h0, 0, 4'h0, 32'h0, 32'h0);
    @(negedge clk);
    chk("rstrel instr_rvalid", 32'(instr_rvalid), 32'h1);
    chk("rstrel instr_rdata", instr_rdata, 32'hC0DE0010);
    chk("rstrel data_rvalid2", 32'(data_rvalid), 32'h0);

    // ---------------- instr pulsed for one cycle under data load ---------
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      drive((k == 0), 32'h30, 1, 4'h0, 32'hC, 32'h0);
      @(negedge clk);
      chk($sformatf("pulse%0d data_gnt", k), 32'(data_gnt), 32'h1);
      chk($sformatf("pulse%0d instr_gnt", k), 32'(instr_gnt), 32'h0);
      chk($sformatf("pulse%0d instr_rvalid", k), 32'(instr_rvalid), 32'h0);
      chk($sformatf("pulse%0d streak", k), 32'(dut.streak_q), (k == 1) ? 32'h1 : 32'h0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
